// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: generic pipeline stage with a valid/ready handshake and a
// 2-entry skid buffer.
//
// The main register drives the downstream port. The skid register catches the
// one extra entry that arrives in the cycle downstream first stalls. Because of
// this, up_ready_o is decoded from state flops only and never sees dn_ready_i.
//
// Optional macro PIPE_PERF_EN adds saturating stall and flush counters.
module pipe_stage_skid_reg #(
  parameter int DATA_W         = 128,
  parameter int CTRL_W         = 8,
  parameter int FLUSH_CLR_DATA = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  input  logic [CTRL_W-1:0] up_ctrl_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [CTRL_W-1:0] dn_ctrl_o,
  output logic [1:0]        occupancy_o
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  // State value equals the number of held entries.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic                w_in;
  logic                w_out;
  logic                w_ld_main_up;
  logic                w_ld_main_skid;
  logic                w_ld_skid_up;

  assign up_ready_o  = (r_state != S_FULL);
  assign dn_valid_o  = (r_state != S_EMPTY);
  assign occupancy_o = r_state;
  assign dn_data_o   = r_main_data;
  // The main ctrl may still hold a departed entry's control, so gate it with valid.
  assign dn_ctrl_o   = dn_valid_o ? r_main_ctrl : '0;

  assign w_in  = up_valid_i & up_ready_o;
  assign w_out = dn_valid_o & dn_ready_i;

  // State register: entry count, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and register load enables; flush overrides every transfer.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_up   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid_up   = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in) begin
            w_state_nxt  = S_BUSY;
            w_ld_main_up = 1'b1;
          end
        end
        S_BUSY: begin
          if (w_in && w_out) begin
            w_ld_main_up = 1'b1;
          end else if (w_in) begin
            w_state_nxt  = S_FULL;
            w_ld_skid_up = 1'b1;
          end else if (w_out) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out) begin
            w_state_nxt    = S_BUSY;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Payload registers: load from upstream or skid; flush clears ctrl (and optionally data).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush_i) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      if (FLUSH_CLR_DATA != 0) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      if (w_ld_main_up) begin
        r_main_data <= up_data_i;
        r_main_ctrl <= up_ctrl_i;
      end else if (w_ld_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_ld_skid_up) begin
        r_skid_data <= up_data_i;
        r_skid_ctrl <= up_ctrl_i;
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Saturating counters of backpressure cycles and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (dn_valid_o && !dn_ready_i) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (flush_i)                   r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios followed by a long
// randomized run, all checked against a queue model of the held entries.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush_i = 1'b0;
  logic              up_valid_i = 1'b0;
  logic              up_ready_o;
  logic [DATA_W-1:0] up_data_i = '0;
  logic [CTRL_W-1:0] up_ctrl_i = '0;
  logic              dn_valid_o;
  logic              dn_ready_i = 1'b0;
  logic [DATA_W-1:0] dn_data_o;
  logic [CTRL_W-1:0] dn_ctrl_o;
  logic [1:0]        occupancy_o;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
`endif

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLUSH_CLR_DATA(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
    .up_data_i(up_data_i), .up_ctrl_i(up_ctrl_i),
    .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i),
    .dn_data_o(dn_data_o), .dn_ctrl_o(dn_ctrl_o),
    .occupancy_o(occupancy_o)
`ifdef PIPE_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  ent_t       q[$];
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    chk("up_ready", 136'(up_ready_o), 136'(n < 2));
    chk("dn_valid", 136'(dn_valid_o), 136'(n > 0));
    chk("occupancy", 136'(occupancy_o), 136'(n));
    chk("dn_ctrl", 136'(dn_ctrl_o), (n > 0) ? 136'(q[0].c) : 136'(0));
    if (n > 0) chk("dn_data", 136'(dn_data_o), 136'(q[0].d));
`ifdef PIPE_PERF_EN
    chk("stall_cnt", 136'(stall_cnt_o), 136'(m_stall));
    chk("flush_cnt", 136'(flush_cnt_o), 136'(m_flush));
`endif
  endtask

  // Check, advance the model by the current inputs, then advance one clock.
  task automatic tick();
    bit vld, rdy;
    check_outputs();
    vld = (q.size() > 0);
    rdy = (q.size() < 2);
    if (vld && !dn_ready_i && m_stall != '1) m_stall = m_stall + 1'b1;
    if (flush_i && m_flush != '1) m_flush = m_flush + 1'b1;
    if (flush_i) begin
      q.delete();
    end else begin
      if (vld && dn_ready_i) void'(q.pop_front());
      if (up_valid_i && rdy) q.push_back({up_data_i, up_ctrl_i});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    up_valid_i = 1'b1;
    up_data_i  = d;
    up_ctrl_i  = c;
    tick();
  endtask

  task automatic check_reset_zero();
    chk("rst_dn_valid", 136'(dn_valid_o), 136'(0));
    chk("rst_up_ready", 136'(up_ready_o), 136'(1));
    chk("rst_occupancy", 136'(occupancy_o), 136'(0));
    chk("rst_dn_data", 136'(dn_data_o), 136'(0));
    chk("rst_dn_ctrl", 136'(dn_ctrl_o), 136'(0));
  endtask

  task automatic model_reset();
    q.delete();
    m_stall = '0;
    m_flush = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming with downstream always ready.
    dn_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) push(DATA_W'(8'h0A + i), 8'h03);
    up_valid_i = 1'b0;
    tick();
    tick();

    // Backpressure into the skid register and drain.
    dn_ready_i = 1'b0;
    push(DATA_W'(8'h20), 8'h11);
    push(DATA_W'(8'h21), 8'h12);
    push(DATA_W'(8'h22), 8'h13);
    up_valid_i = 1'b0;
    dn_ready_i = 1'b1;
    tick();
    tick();
    tick();

    // Flush while full with simultaneous in/out attempts.
    dn_ready_i = 1'b0;
    push(DATA_W'(8'h30), 8'h21);
    push(DATA_W'(8'h31), 8'h22);
    flush_i    = 1'b1;
    dn_ready_i = 1'b1;
    push(DATA_W'(8'h32), 8'h23);
    flush_i    = 1'b0;
    up_valid_i = 1'b0;
    chk("flush_data_zero", 136'(dn_data_o), 136'(0));
    tick();

    // Asynchronous reset while full, then first entry after release.
    dn_ready_i = 1'b0;
    push(DATA_W'(8'h40), 8'h31);
    push(DATA_W'(8'h41), 8'h32);
    up_valid_i = 1'b0;
    check_outputs();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    dn_ready_i = 1'b1;
    push(DATA_W'(8'h50), 8'h41);
    up_valid_i = 1'b0;
    tick();

    // Long stall then three flush cycles exercises counter saturation.
    dn_ready_i = 1'b0;
    push(DATA_W'(8'h60), 8'h51);
    up_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    flush_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    flush_i = 1'b0;
`ifdef PIPE_PERF_EN
    chk("stall_saturated", 136'(stall_cnt_o), 136'(15));
    chk("flush_three", 136'(flush_cnt_o), 136'(3));
`endif
    tick();

    // Randomized traffic; perturbing dn_ready_i and up_* mid-cycle must not move outputs.
    for (int i = 0; i < 10000; i++) begin
      up_valid_i = ($urandom_range(0, 3) != 0);
      up_data_i  = {$urandom, $urandom, $urandom, $urandom};
      up_ctrl_i  = 8'($urandom);
      flush_i    = ($urandom_range(0, 63) == 0);
      dn_ready_i = ~dn_ready_i;
      up_valid_i = ~up_valid_i;
      #1;
      check_outputs();
      dn_ready_i = ($urandom_range(0, 2) != 0);
      up_valid_i = ~up_valid_i;
      #1;
      tick();
    end
    flush_i    = 1'b0;
    up_valid_i = 1'b0;
    dn_ready_i = 1'b1;
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
